// File: rtl/wb_pkg.sv
// Shared constants and types for the write-back / retire stage.
// ExcCode values match the CP0 Cause.ExcCode encoding.
package wb_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
// idx is 0 when no request is set.
module exc_prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        hit = |req;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/wb_retire.sv
// Write-back and retire stage: commits RF and HI/LO writes, arbitrates
// exceptions and interrupts, and holds cancel while the front end refills.
module wb_retire
    import wb_pkg::*;
#(
    parameter int                DATA_W       = 32,
    parameter int                NUM_EXC      = 8,
    parameter int                CODE_W       = 5,
    parameter int                FLUSH_CYCLES = 2,
    parameter logic [CODE_W-1:0] INT_CODE     = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wb_valid,
    input  logic                      wb_wen,
    input  logic [4:0]                wb_wdest,
    input  logic [DATA_W-1:0]         wb_result,
    input  logic [DATA_W-1:0]         wb_lo,
    input  logic                      hi_write,
    input  logic                      lo_write,
    input  logic                      mfhi,
    input  logic                      mflo,
    input  logic [DATA_W-1:0]         cp0_rdata,
    input  logic                      mfc0,
    input  logic [DATA_W-1:0]         wb_pc,
    input  logic [NUM_EXC-1:0]        exc_vec,
    input  logic [NUM_EXC*CODE_W-1:0] exc_codes,
    input  logic [NUM_EXC-1:0]        bva_src,
    input  logic [DATA_W-1:0]         mem_badvaddr,
    input  logic                      int_req,
    input  logic                      eret,
    input  logic [DATA_W-1:0]         epc_in,
    input  logic [DATA_W-1:0]         exc_base,
    output logic                      rf_wen,
    output logic [4:0]                rf_wdest,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic [4:0]                fwd_dest,
    output logic [DATA_W-1:0]         hi_data,
    output logic [DATA_W-1:0]         lo_data,
    output logic                      cancel,
    output logic                      redir_valid,
    output logic [DATA_W-1:0]         redir_pc,
    output logic                      cp0_exc_we,
    output logic [CODE_W-1:0]         cp0_exc_code,
    output logic [DATA_W-1:0]         cp0_epc,
    output logic                      cp0_bva_we,
    output logic [DATA_W-1:0]         cp0_bva,
    output logic [31:0]               retired
);

    localparam int         IDX_W      = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1;
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t             state;
    logic [3:0]         flush_cnt;
    logic               take;
    logic               enc_hit;
    logic [IDX_W-1:0]   win_idx;
    logic               exc_hit;
    logic [CODE_W-1:0]  exc_code;
    logic               bva_sel;
    logic               commit;
    logic               redirect;

    // wb_valid has no ready: the instruction is taken only in RUN and is
    // silently squashed in FLUSH, so upstream never stalls on this stage.
    assign take = wb_valid & (state == RUN);

    exc_prio_enc #(
        .N     (NUM_EXC),
        .IDX_W (IDX_W)
    ) u_prio (
        .req (exc_vec),
        .hit (enc_hit),
        .idx (win_idx)
    );

    // The interrupt outranks every synchronous source and never loads BadVAddr.
    assign exc_hit  = int_req | enc_hit;
    assign exc_code = int_req ? INT_CODE : exc_codes[CODE_W*int'(win_idx) +: CODE_W];
    assign bva_sel  = ~int_req & enc_hit & bva_src[win_idx];

    assign commit   = take & ~exc_hit;
    assign redirect = take & (exc_hit | eret);

    assign rf_wen   = commit & wb_wen;
    assign rf_wdest = wb_wdest;
    assign fwd_dest = rf_wen ? wb_wdest : 5'd0;
    assign rf_wdata = mfhi ? hi_data :
                      mflo ? lo_data :
                      mfc0 ? cp0_rdata : wb_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            flush_cnt <= '0;
            cancel    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                        cancel    <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 4'd0) begin
                        state  <= RUN;
                        cancel <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                default: begin
                    state     <= RUN;
                    flush_cnt <= '0;
                    cancel    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            redir_valid  <= 1'b0;
            redir_pc     <= '0;
            cp0_exc_we   <= 1'b0;
            cp0_exc_code <= '0;
            cp0_epc      <= '0;
            cp0_bva_we   <= 1'b0;
            cp0_bva      <= '0;
        end else begin
            redir_valid <= redirect;
            cp0_exc_we  <= take & exc_hit;
            cp0_bva_we  <= take & bva_sel;
            if (redirect) begin
                redir_pc <= exc_hit ? exc_base : epc_in;
            end
            if (take & exc_hit) begin
                cp0_exc_code <= exc_code;
                cp0_epc      <= wb_pc;
            end
            if (take & bva_sel) begin
                cp0_bva <= mem_badvaddr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_data <= '0;
            lo_data <= '0;
            retired <= '0;
        end else begin
            if (commit & hi_write) begin
                hi_data <= wb_result;
            end
            if (commit & lo_write) begin
                lo_data <= wb_lo;
            end
            if (commit) begin
                retired <= retired + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_retire.sv
// Bench for wb_retire: directed scenarios then random traffic, checked against
// a cycle-level behavioural model and a queue of expected redirect targets.
module tb_wb_retire;

    localparam int         DW = 32;
    localparam int         NE = 8;
    localparam int         CW = 5;
    localparam int         FC = 4;
    localparam logic [4:0] IC = 5'd0;

    logic              clk = 1'b0;
    logic              reset;
    logic              wb_valid, wb_wen;
    logic [4:0]        wb_wdest;
    logic [DW-1:0]     wb_result, wb_lo;
    logic              hi_write, lo_write, mfhi, mflo, mfc0;
    logic [DW-1:0]     cp0_rdata, wb_pc;
    logic [NE-1:0]     exc_vec, bva_src;
    logic [NE*CW-1:0]  exc_codes;
    logic [DW-1:0]     mem_badvaddr;
    logic              int_req, eret;
    logic [DW-1:0]     epc_in, exc_base;
    logic              rf_wen;
    logic [4:0]        rf_wdest, fwd_dest;
    logic [DW-1:0]     rf_wdata, hi_data, lo_data;
    logic              cancel, redir_valid, cp0_exc_we, cp0_bva_we;
    logic [DW-1:0]     redir_pc, cp0_epc, cp0_bva;
    logic [CW-1:0]     cp0_exc_code;
    logic [31:0]       retired;

    // model state
    logic [DW-1:0] m_hi, m_lo, m_redir_pc, m_epc, m_bva;
    logic [31:0]   m_ret;
    logic [CW-1:0] m_code;
    logic          m_redir_valid, m_exc_we, m_bva_we;
    int            m_flush;
    logic [DW-1:0] exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_retire #(
        .DATA_W(DW), .NUM_EXC(NE), .CODE_W(CW), .FLUSH_CYCLES(FC), .INT_CODE(IC)
    ) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_wen(wb_wen),
        .wb_wdest(wb_wdest), .wb_result(wb_result), .wb_lo(wb_lo),
        .hi_write(hi_write), .lo_write(lo_write), .mfhi(mfhi), .mflo(mflo),
        .cp0_rdata(cp0_rdata), .mfc0(mfc0), .wb_pc(wb_pc), .exc_vec(exc_vec),
        .exc_codes(exc_codes), .bva_src(bva_src), .mem_badvaddr(mem_badvaddr),
        .int_req(int_req), .eret(eret), .epc_in(epc_in), .exc_base(exc_base),
        .rf_wen(rf_wen), .rf_wdest(rf_wdest), .rf_wdata(rf_wdata),
        .fwd_dest(fwd_dest), .hi_data(hi_data), .lo_data(lo_data),
        .cancel(cancel), .redir_valid(redir_valid), .redir_pc(redir_pc),
        .cp0_exc_we(cp0_exc_we), .cp0_exc_code(cp0_exc_code), .cp0_epc(cp0_epc),
        .cp0_bva_we(cp0_bva_we), .cp0_bva(cp0_bva), .retired(retired)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        wb_valid = 0; wb_wen = 0; wb_wdest = 0; wb_result = 0; wb_lo = 0;
        hi_write = 0; lo_write = 0; mfhi = 0; mflo = 0; mfc0 = 0;
        cp0_rdata = 0; wb_pc = 0; exc_vec = 0; bva_src = 0;
        mem_badvaddr = 0; int_req = 0; eret = 0; epc_in = 0;
    endtask

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_ret = 0; m_redir_pc = 0; m_epc = 0; m_bva = 0;
        m_code = 0; m_redir_valid = 0; m_exc_we = 0; m_bva_we = 0; m_flush = 0;
        exp_q.delete();
    endtask

    // Interrupt first, then the lowest requesting source.
    task automatic model_arb(output logic hit, output logic [CW-1:0] code, output logic bva);
        logic found;
        hit = 0; code = 0; bva = 0; found = 0;
        if (int_req) begin
            hit = 1; code = IC;
        end else begin
            for (int i = 0; i < NE; i++) begin
                if (!found && exc_vec[i]) begin
                    found = 1; hit = 1;
                    code = exc_codes[i*CW +: CW];
                    bva = bva_src[i];
                end
            end
        end
    endtask

    task automatic check_regs();
        check("cancel", cancel, m_flush > 0);
        check("redir_valid", redir_valid, m_redir_valid);
        check("redir_pc", redir_pc, m_redir_pc);
        check("cp0_exc_we", cp0_exc_we, m_exc_we);
        check("cp0_exc_code", cp0_exc_code, m_code);
        check("cp0_epc", cp0_epc, m_epc);
        check("cp0_bva_we", cp0_bva_we, m_bva_we);
        check("cp0_bva", cp0_bva, m_bva);
        check("hi_data", hi_data, m_hi);
        check("lo_data", lo_data, m_lo);
        check("retired", retired, m_ret);
    endtask

    // Called just after a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        logic          take, hit, bva, wen;
        logic [CW-1:0] code;
        logic [DW-1:0] wd;
        #1;
        take = wb_valid && (m_flush == 0);
        model_arb(hit, code, bva);
        wen = take && wb_wen && !hit;
        wd = mfhi ? m_hi : mflo ? m_lo : mfc0 ? cp0_rdata : wb_result;
        check("rf_wen", rf_wen, wen);
        check("rf_wdest", rf_wdest, wb_wdest);
        check("rf_wdata", rf_wdata, wd);
        check("fwd_dest", fwd_dest, wen ? wb_wdest : 5'd0);
        @(posedge clk);
        m_redir_valid = 0; m_exc_we = 0; m_bva_we = 0;
        if (take && hit) begin
            m_exc_we = 1; m_code = code; m_epc = wb_pc;
            m_redir_valid = 1; m_redir_pc = exc_base;
            if (bva) begin
                m_bva_we = 1; m_bva = mem_badvaddr;
            end
        end else if (take) begin
            if (hi_write) m_hi = wb_result;
            if (lo_write) m_lo = wb_lo;
            m_ret = m_ret + 32'd1;
            if (eret) begin
                m_redir_valid = 1; m_redir_pc = epc_in;
            end
        end
        if (m_redir_valid) begin
            m_flush = FC;
            exp_q.push_back(m_redir_pc);
        end else if (m_flush > 0) begin
            m_flush--;
        end
        #1;
        check_regs();
        if (redir_valid) begin
            if (exp_q.size() == 0) check("redir_unexpected", 1'b1, 1'b0);
            else check("redir_scoreboard", redir_pc, exp_q.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        clear_inputs();
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        reset = 1;
        clear_inputs();
        @(posedge clk);
        #1;
        model_reset();
        check_regs();
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        logic [CW-1:0] code_tab[NE];
        code_tab = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd8, 5'd9, 5'd12};
        for (int i = 0; i < NE; i++) exc_codes[i*CW +: CW] = code_tab[i];
        exc_base = 32'hBFC0_0380;
        clear_inputs();
        model_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();

        // plain retire
        wb_valid = 1; wb_wen = 1; wb_wdest = 5; wb_result = 32'h1234;
        #1;
        check("add_wen", rf_wen, 1'b1);
        check("add_wdata", rf_wdata, 32'h1234);
        cycle();
        check("add_retired", retired, 32'd1);

        // faulting load
        clear_inputs();
        wb_valid = 1; wb_wen = 1; wb_wdest = 7; exc_vec = 8'b0000_1000; bva_src = 8'b0000_1000;
        mem_badvaddr = 32'h8000_1003; wb_pc = 32'hBFC0_0100;
        cycle();
        check("load_exc_we", cp0_exc_we, 1'b1);
        check("load_code", cp0_exc_code, 5'd4);
        check("load_epc", cp0_epc, 32'hBFC0_0100);
        check("load_bva", cp0_bva, 32'h8000_1003);
        check("load_redir", redir_pc, 32'hBFC0_0380);
        check("load_cancel", cancel, 1'b1);
        idle(FC + 1);

        // priority: interrupt beats sources, then lowest source wins
        wb_valid = 1; int_req = 1; exc_vec = 8'b0000_1010; bva_src = 8'hFF;
        cycle();
        check("prio_int_code", cp0_exc_code, 5'd0);
        check("prio_int_nobva", cp0_bva_we, 1'b0);
        idle(FC + 1);
        wb_valid = 1; exc_vec = 8'b0000_1010;
        cycle();
        check("prio_src1_code", cp0_exc_code, 5'd2);
        idle(FC + 1);

        // HI/LO then moves from them
        wb_valid = 1; hi_write = 1; lo_write = 1; wb_result = 32'hFFFF_FFFF; wb_lo = 32'h1;
        cycle();
        clear_inputs(); wb_valid = 1; wb_wen = 1; wb_wdest = 8; mfhi = 1;
        cycle();
        check("mfhi_data", rf_wdata, 32'hFFFF_FFFF);
        clear_inputs(); wb_valid = 1; wb_wen = 1; wb_wdest = 9; mflo = 1;
        cycle();
        check("mflo_data", rf_wdata, 32'h1);

        // ERET, then an MTHI squashed during the flush
        clear_inputs(); wb_valid = 1; eret = 1; epc_in = 32'hBFC0_0200;
        cycle();
        check("eret_redir", redir_pc, 32'hBFC0_0200);
        check("eret_no_exc", cp0_exc_we, 1'b0);
        clear_inputs(); wb_valid = 1; hi_write = 1; wb_result = 32'hDEAD_BEEF;
        cycle();
        check("mthi_squashed", hi_data, 32'hFFFF_FFFF);
        idle(FC);

        // interrupt held through a flush is taken on the first RUN instruction
        wb_valid = 1; exc_vec = 8'b0100_0000;
        cycle();
        clear_inputs(); int_req = 1;
        for (int i = 0; i < FC; i++) begin
            wb_valid = 1;
            cycle();
        end
        cycle();
        check("int_after_flush", cp0_exc_code, 5'd0);
        idle(FC + 1);

        // reset in the middle of a flush
        wb_valid = 1; exc_vec = 8'b0000_0001;
        cycle();
        clear_inputs();
        cycle();
        do_reset();
        check("rst_cancel", cancel, 1'b0);
        idle(2);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            wb_valid  = ($urandom_range(0, 3) != 0);
            wb_wen    = $urandom_range(0, 1);
            wb_wdest  = 5'($urandom_range(0, 31));
            wb_result = $urandom;
            wb_lo     = $urandom;
            hi_write  = ($urandom_range(0, 5) == 0);
            lo_write  = ($urandom_range(0, 5) == 0);
            mfhi      = ($urandom_range(0, 7) == 0);
            mflo      = ($urandom_range(0, 7) == 0);
            mfc0      = ($urandom_range(0, 7) == 0);
            cp0_rdata = $urandom;
            wb_pc     = $urandom;
            exc_vec   = ($urandom_range(0, 9) == 0) ? NE'($urandom) : '0;
            bva_src   = NE'($urandom);
            exc_codes = {$urandom, $urandom};
            mem_badvaddr = $urandom;
            int_req   = ($urandom_range(0, 19) == 0);
            eret      = ($urandom_range(0, 14) == 0);
            epc_in    = $urandom;
            exc_base  = $urandom;
            if ($urandom_range(0, 299) == 0) do_reset();
            else cycle();
        end
        idle(FC + 2);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
